// File: rtl/fifo_sync_flex.sv
// rtl/fifo_sync_flex.sv - synchronous FIFO with FWFT/registered read, fill level, thresholds, flush and sticky error flags
module fifo_sync_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_BITS     = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_BITS) - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  clr_flags_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C  = (ADDR_BITS + 1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] AEMPTY_C = (ADDR_BITS + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_BITS-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 wr_acc, rd_acc;

  // Status decoded from the registered count so all flags move together with it.
  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush masks both requests; a write while full or read while empty is never accepted.
  assign wr_acc = w_en & ~fifo_full  & ~flush_i;
  assign rd_acc = r_en & ~fifo_empty & ~flush_i;

  // Next-state for pointers, fill level and sticky flags (set beats clear).
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_i) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (clr_flags_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (w_en & fifo_full  & ~flush_i) overflow_d  = 1'b1;
    if (r_en & fifo_empty & ~flush_i) underflow_d = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[w_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is always presented; valid whenever something is stored.
    assign data_out   = mem[r_ptr_q];
    assign data_valid = ~fifo_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  valid_q, valid_d;

    // Output register loads on an accepted read, otherwise holds; valid pulses for one cycle.
    always_comb begin
      rdata_d = rdata_q;
      valid_d = rd_acc;
      if (rd_acc) rdata_d = mem[r_ptr_q];
    end

    // Read data register with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rdata_q <= '0;
        valid_q <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        valid_q <= valid_d;
      end
    end

    assign data_out   = rdata_q;
    assign data_valid = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// tb/tb_fifo_sync_flex.sv - self-checking bench for fifo_sync_flex (registered and FWFT instances)
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wen = 1'b0;
  logic       ren = 1'b0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [4:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  fifo_sync_flex #(.DATA_WIDTH(8), .ADDR_BITS(4), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut0 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .clr_flags_i(clr),
    .data_in(din), .w_en(wen), .r_en(ren),
    .data_out(dout0), .data_valid(dv0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

  fifo_sync_flex #(.DATA_WIDTH(8), .ADDR_BITS(4), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut1 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .clr_flags_i(clr),
    .data_in(din), .w_en(wen), .r_en(ren),
    .data_out(dout1), .data_valid(dv1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wen = 1'b0; ren = 1'b0; flush = 1'b0; clr = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cnt0 !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    n_checks++; if ({empty0, ae0, full0, af0} !== 4'b1100) begin n_fail++; $display("FAIL reset_status got=%b exp=1100", {empty0, ae0, full0, af0}); end
    n_checks++; if (dout0 !== 8'h00 || dv0 !== 1'b0) begin n_fail++; $display("FAIL reset_data got=%h/%b exp=00/0", dout0, dv0); end
    n_checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", ovf0, unf0); end
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      din = base + 8'(i); wen = 1'b1;
      sb.push_back(din);
      cycle();
      n_checks++; if (cnt0 !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", cnt0, i + 1); end
      n_checks++; if (ae0 !== (i + 1 <= 2) || af0 !== (i + 1 >= 12) || full0 !== (i + 1 == 16)) begin
        n_fail++; $display("FAIL fill_thresh cnt=%0d got ae/af/full=%b%b%b", i + 1, ae0, af0, full0);
      end
    end
    wen = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      ren = 1'b1;
      cycle();
      exp_d = sb.pop_front();
      n_checks++; if (dv0 !== 1'b1 || dout0 !== exp_d) begin n_fail++; $display("FAIL drain_data got=%h/%b exp=%h/1", dout0, dv0, exp_d); end
    end
    ren = 1'b0;
  endtask

  task automatic test_fill_drain();
    fill16(8'h01);
    drain(16);
    cycle();
    n_checks++; if (dv0 !== 1'b0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL drain_end got dv=%b empty=%b exp 0/1", dv0, empty0); end
  endtask

  task automatic test_overflow_underflow();
    fill16(8'h60);
    din = 8'hAA; wen = 1'b1;
    cycle();
    wen = 1'b0;
    n_checks++; if (cnt0 !== 5'd16 || ovf0 !== 1'b1) begin n_fail++; $display("FAIL overflow_set got cnt=%0d ovf=%b exp 16/1", cnt0, ovf0); end
    cycle();
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got=%b exp=1", ovf0); end
    drain(16);
    ren = 1'b1;
    cycle();
    ren = 1'b0;
    n_checks++; if (unf0 !== 1'b1 || dv0 !== 1'b0) begin n_fail++; $display("FAIL underflow_set got unf=%b dv=%b exp 1/0", unf0, dv0); end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    n_checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_fail++; $display("FAIL clr_flags got=%b%b exp=00", ovf0, unf0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      din = 8'h20 + 8'(i); wen = 1'b1; sb.push_back(din);
      cycle();
    end
    for (int i = 0; i < 40; i++) begin
      din = 8'h80 + 8'(i); wen = 1'b1; ren = 1'b1; sb.push_back(din);
      cycle();
      exp_d = sb.pop_front();
      n_checks++; if (cnt0 !== 5'd5) begin n_fail++; $display("FAIL b2b_count got=%0d exp=5", cnt0); end
      n_checks++; if (dv0 !== 1'b1 || dout0 !== exp_d) begin n_fail++; $display("FAIL b2b_data got=%h/%b exp=%h/1", dout0, dv0, exp_d); end
    end
    wen = 1'b0; ren = 1'b0;
    drain(5);
    cycle();
    n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_fwft();
    do_reset();
    din = 8'h3C; wen = 1'b1;
    cycle();
    wen = 1'b0;
    n_checks++; if (dout1 !== 8'h3C || dv1 !== 1'b1) begin n_fail++; $display("FAIL fwft_head got=%h/%b exp=3c/1", dout1, dv1); end
    cycle();
    n_checks++; if (dout1 !== 8'h3C || dv1 !== 1'b1) begin n_fail++; $display("FAIL fwft_hold got=%h/%b exp=3c/1", dout1, dv1); end
    ren = 1'b1;
    cycle();
    ren = 1'b0;
    n_checks++; if (dv1 !== 1'b0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL fwft_pop got dv=%b empty=%b exp 0/1", dv1, empty1); end
  endtask

  task automatic test_flush();
    do_reset();
    ren = 1'b1;
    cycle();
    ren = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din = 8'h10 + 8'(i); wen = 1'b1;
      cycle();
    end
    din = 8'h99; wen = 1'b1; ren = 1'b1; flush = 1'b1;
    cycle();
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
    n_checks++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || dv0 !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got cnt=%0d empty=%b dv=%b exp 0/1/0", cnt0, empty0, dv0);
    end
    n_checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b1) begin n_fail++; $display("FAIL flush_flags got=%b%b exp=01", ovf0, unf0); end
    n_checks++; if (dv1 !== 1'b0 || cnt1 !== 5'd0) begin n_fail++; $display("FAIL flush_fwft got dv=%b cnt=%0d exp 0/0", dv1, cnt1); end
    din = 8'h55; wen = 1'b1; sb.push_back(din);
    cycle();
    wen = 1'b0;
    n_checks++; if (dout1 !== 8'h55 || dv1 !== 1'b1) begin n_fail++; $display("FAIL flush_fwft_after got=%h/%b exp=55/1", dout1, dv1); end
    drain(1);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      din = 8'hC0 + 8'(i); wen = 1'b1;
      cycle();
    end
    wen = 1'b0; ren = 1'b1;
    cycle();
    ren = 1'b0;
    n_checks++; if (cnt0 !== 5'd7 || dout0 !== 8'hC0 || dv0 !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre got cnt=%0d d=%h dv=%b exp 7/c0/1", cnt0, dout0, dv0);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || dv0 !== 1'b0 || dout0 !== 8'h00 || cnt1 !== 5'd0) begin
      n_fail++; $display("FAIL areset_immediate got cnt=%0d empty=%b dv=%b d=%h exp 0/1/0/00", cnt0, empty0, dv0, dout0);
    end
    #1 reset = 1'b0;
    cycle();
    n_checks++; if (empty0 !== 1'b1 || unf0 !== 1'b0) begin n_fail++; $display("FAIL areset_after got empty=%b unf=%b exp 1/0", empty0, unf0); end
    ren = 1'b1;
    cycle();
    ren = 1'b0;
    n_checks++; if (unf0 !== 1'b1 || dv0 !== 1'b0) begin n_fail++; $display("FAIL areset_underflow got unf=%b dv=%b exp 1/0", unf0, dv0); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_back_to_back();
    test_fwft();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
